// File: rtl/axis_timing_gen.sv
// axis_timing_gen: one axis (H or V) of a video timing generator; all outputs registered and mutually aligned.
module axis_timing_gen #(
   parameter int BIT_DIM  = 11,
   parameter int ACTIVE   = 640,
   parameter int FRONT    = 16,
   parameter int SYNC     = 96,
   parameter int BACK     = 48,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   output logic [BIT_DIM-1:0] pos_o,
   output logic               de_o,
   output logic               sync_o,
   output logic               tc_o
);
   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
   localparam logic [BIT_DIM-1:0] LAST    = BIT_DIM'(TOTAL - 1);
   localparam logic [BIT_DIM-1:0] ACT_END = BIT_DIM'(ACTIVE);
   localparam logic [BIT_DIM-1:0] SYNC_LO = BIT_DIM'(ACTIVE + FRONT);
   localparam logic [BIT_DIM-1:0] SYNC_HI = BIT_DIM'(ACTIVE + FRONT + SYNC - 1);
   if (64'(TOTAL - 1) >= (64'd1 << BIT_DIM)) begin : g_bad_dim
      $error("axis_timing_gen: TOTAL-1 does not fit in BIT_DIM bits");
   end
   if (ACTIVE == 0 || SYNC == 0) begin : g_bad_len
      $error("axis_timing_gen: ACTIVE and SYNC must be non-zero");
   end
   logic [BIT_DIM-1:0] cnt, cnt_nxt;
   logic               de, sync_act, at_last;
   always_comb begin
      at_last  = cnt == LAST;
      de       = cnt < ACT_END;
      sync_act = cnt >= SYNC_LO && cnt <= SYNC_HI;
      cnt_nxt  = clr ? '0 : !en ? cnt : at_last ? '0 : cnt + BIT_DIM'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         pos_o  <= '0;
         de_o   <= 1'b0;
         sync_o <= ~SYNC_POL;
         tc_o   <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         pos_o  <= cnt;
         de_o   <= de;
         sync_o <= sync_act ? SYNC_POL : ~SYNC_POL;
         tc_o   <= at_last && en && !clr;
      end
   end
endmodule
